sweep_scheduler: RTL and testbench
==================================

// Module: sweep_scheduler
// PURPOSE
//  Shares one NDATA-entry index sweep (the frame-sample counter datapath) between two requesters.
//  Grants the sweep round-robin and generates index beats 0..NDATA-1 under a valid/ready handshake.
//  Pulses done to the granted requester when its sweep completes.
//  Sits between the encoder/decoder engines (requesters) and the shared sample buffer (consumer).
// PARAMETERS
//  NDATA      128            sweep length in beats; legal range >= 2, need not be a power of 2
//  NDATA_LOG  $clog2(NDATA)  localparam; width of idx
// PORTS
//  clk      in   1          single clock; all state updates on posedge clk
//  rst      in   1          synchronous reset, active-high
//  req      in   2          req[i]=1: requester i wants a full sweep; level-sensitive
//  abort    in   1          terminate the current sweep
//  idx_rdy  in   1          consumer accepts the current idx beat
//  gnt      out  2          one-hot grant, held for the whole sweep; 00 when idle
//  idx      out  NDATA_LOG  current sweep index
//  idx_vld  out  1          idx is valid this cycle
//  last     out  1          idx_vld && idx==NDATA-1
//  done     out  2          one-cycle pulse to the requester whose sweep completed normally
//  busy     out  1          1 in SWEEP and DONE states
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE, gnt=00, idx=0, idx_vld=0, done=00, busy=0, rr_last=1.
//   Reset overrides everything, including mid-sweep.
//  FSM with 3 states: IDLE, SWEEP, DONE.
//  IDLE: gnt=00, idx_vld=0, idx=0.
//   If req!=00, go to SWEEP next cycle with gnt set.
//   Arbitration: only req[i] set -> grant i. Both set -> grant !rr_last.
//   Latency: req sampled at edge N -> gnt and idx_vld=1 with idx=0 visible after edge N+1.
//  SWEEP: idx_vld=1, gnt held.
//   Beat accepted when idx_vld && idx_rdy.
//   On accept with idx<NDATA-1: idx<=idx+1.
//   On accept with idx==NDATA-1: go to DONE. No wrap-around beat is emitted.
//   idx_rdy=0: idx holds; no beat is skipped or duplicated.
//   req changes during SWEEP are ignored; the sweep always runs to completion or abort.
//  DONE: for exactly one cycle, done[g]=1 for the granted g, gnt=00, idx_vld=0, idx=0, busy=1.
//   rr_last<=g. Next state is IDLE, so the earliest next grant is 2 cycles after DONE.
//  abort=1 in SWEEP: has priority over a same-cycle accept, and that beat counts as not taken.
//   Next cycle: state=IDLE, gnt=00, idx_vld=0, idx=0, no done pulse; rr_last<=g for fairness.
//  abort in IDLE or DONE is ignored.
//  Outputs are registered, except last (decoded from registered idx/idx_vld).
//  idx arithmetic is NDATA_LOG bits wide; the compare against NDATA-1 uses the same width.
// TESTING  (NDATA=8 unless noted)
//  1 Reset: rst=1 for 2 cycles with req=11 -> gnt=00, idx=0, idx_vld=0, done=00, busy=0 throughout.
//  2 Single sweep: req=01 at edge 0, idx_rdy=1 -> gnt=01 and idx 0..7 after edges 1..8;
//    last=1 with idx=7; done=01 after edge 9 only; busy=0 after edge 10.
//  3 Backpressure: idx_rdy random 50% -> exactly 8 accepted beats in order 0..7, idx stable while
//    rdy=0, single done pulse; repeat with NDATA=5 (non-power-of-2) -> beats 0..4 only.
//  4 Fairness: req=11 held -> grants alternate 01,10,01,10, starting with 01 after reset.
//  5 Abort: abort=1 when idx=3 and idx_rdy=1 -> next cycle gnt=00, idx_vld=0, idx=0, done=00;
//    with req=11 held the next grant is 10.
//  6 Reset mid-sweep: rst=1 when idx=5 with gnt=10 -> next cycle all outputs at reset values;
//    with req=11 the next grant is 01.

Source files
------------

// File: rtl/sweep_scheduler.sv
// Purpose : round-robin share of one NDATA-beat index sweep between two requesters; idx beats 0..NDATA-1 under valid/ready.
// Latency : request seen at a clock edge -> grant and idx=0 visible one cycle later; done pulses the cycle after the last beat is accepted.
// Backpr. : idx_rdy=0 holds idx (no skip, no duplicate); abort wins over a same-cycle accept and returns to idle without done.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   req[1:0]      level-sensitive sweep requests from the two engines
//   abort         terminate the sweep in progress (ignored outside SWEEP)
//   idx_rdy       consumer accepts the current beat
//   gnt[1:0]      one-hot grant held for the whole sweep, 00 otherwise
//   idx, idx_vld  current sweep index and its valid
//   last          idx_vld && idx==NDATA-1
//   done[1:0]     one-cycle pulse to the requester whose sweep completed normally
//   busy          high in SWEEP and DONE
module sweep_scheduler #(
  parameter  int NDATA     = 128,
  localparam int NDATA_LOG = $clog2(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic                 abort,
  input  logic                 idx_rdy,
  output logic [1:0]           gnt,
  output logic [NDATA_LOG-1:0] idx,
  output logic                 idx_vld,
  output logic                 last,
  output logic [1:0]           done,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [NDATA_LOG-1:0] IDX_MAX = NDATA_LOG'(NDATA - 1);

  state_t               state_q, state_d;
  logic                 g_q;        // index of the granted requester
  logic                 rr_last_q;  // requester that held the sweep most recently
  logic [NDATA_LOG-1:0] idx_q;
  logic                 pick;

  // Arbitration: a lone request wins outright; a tie goes to whoever did not go last.
  always_comb begin
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~rr_last_q;
      default: pick = 1'b0;
    endcase
  end

  // State register and sweep datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= 1'b0;
      rr_last_q <= 1'b1;
      idx_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (req != 2'b00) g_q <= pick;
        end
        SWEEP: begin
          if (abort) begin
            // aborted sweep still counts as this requester's turn
            idx_q     <= '0;
            rr_last_q <= g_q;
          end else if (idx_rdy) begin
            // idx returns to 0 after the final beat; no wrap beat is shown since idx_vld drops
            if (idx_q == IDX_MAX) idx_q <= '0;
            else                  idx_q <= idx_q + NDATA_LOG'(1);
          end
        end
        DONE: begin
          idx_q     <= '0;
          rr_last_q <= g_q;
        end
        default: idx_q <= '0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != 2'b00) state_d = SWEEP;
      SWEEP: begin
        if (abort)                             state_d = IDLE;
        else if (idx_rdy && idx_q == IDX_MAX)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pure decodes of flops (state, grant index, idx)
  always_comb begin
    gnt     = 2'b00;
    done    = 2'b00;
    idx_vld = 1'b0;
    busy    = 1'b0;
    idx     = idx_q;
    case (state_q)
      SWEEP: begin
        gnt     = g_q ? 2'b10 : 2'b01;
        idx_vld = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        done = g_q ? 2'b10 : 2'b01;
        busy = 1'b1;
      end
      default: begin
        gnt = 2'b00;
      end
    endcase
    last = idx_vld && (idx_q == IDX_MAX);
  end

endmodule

// File: tb/tb_sweep_scheduler.sv
module tb_sweep_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] req8, req5;
  logic       abort8, abort5;
  logic       rdy8, rdy5;

  logic [1:0] gnt8, gnt5, done8, done5;
  logic [2:0] idx8, idx5;
  logic       vld8, vld5, last8, last5, busy8, busy5;

  int n_cmp  = 0;
  int n_fail = 0;

  sweep_scheduler #(.NDATA(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .abort(abort8), .idx_rdy(rdy8),
    .gnt(gnt8), .idx(idx8), .idx_vld(vld8), .last(last8), .done(done8), .busy(busy8)
  );

  sweep_scheduler #(.NDATA(5)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .abort(abort5), .idx_rdy(rdy5),
    .gnt(gnt5), .idx(idx5), .idx_vld(vld5), .last(last5), .done(done5), .busy(busy5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       abort;
    logic       rdy;
    logic [1:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       last;
    logic [1:0] done;
    logic       busy;
    int         tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] rq, input logic ab, input logic rd,
                     input logic [1:0] g, input int i, input logic v,
                     input logic [1:0] d, input logic b, input int tag);
    vec_t e;
    e.rst = r; e.req = rq; e.abort = ab; e.rdy = rd;
    e.gnt = g; e.idx = 3'(i); e.vld = v; e.done = d; e.busy = b; e.tag = tag;
    e.last = v && (i == 7);
    vecs.push_back(e);
  endtask

  // Full uninterrupted sweep with rdy=1 and a constant request: 8 beats, done, idle.
  task automatic add_sweep(input logic [1:0] rq, input logic [1:0] g, input int tag);
    for (int i = 0; i < 8; i++) add(0, rq, 0, 1, g, i, 1, 2'b00, 1, tag);
    add(0, rq, 0, 1, 2'b00, 0, 0, g, 1, tag);
    add(0, rq, 0, 1, 2'b00, 0, 0, 2'b00, 0, tag);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Backpressure run on either instance with random idx_rdy.
  task automatic run_bp(input int which, input int n);
    int   beats, dones, r;
    logic pv, seen;
    logic [2:0] pi;
    logic [1:0] cd;
    beats = 0; dones = 0; seen = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (which == 5) req5 = 2'b01; else req8 = 2'b01;
    for (int c = 0; c < 300 && !seen; c++) begin
      r  = $urandom_range(0, 1);
      if (which == 5) begin rdy5 = r[0]; pv = vld5; pi = idx5; end
      else            begin rdy8 = r[0]; pv = vld8; pi = idx8; end
      @(posedge clk); #1;
      if (which == 5) req5 = 2'b00; else req8 = 2'b00;
      if (pv && r[0]) begin
        chk("bp_accept_order", int'(pi), beats);
        beats++;
      end
      if (which == 5) begin
        if (vld5) begin
          chk("bp_idx", int'(idx5), beats);
          chk("bp_last", int'(last5), int'(idx5 == 3'(n - 1)));
        end
        cd = done5;
      end else begin
        if (vld8) begin
          chk("bp_idx", int'(idx8), beats);
          chk("bp_last", int'(last8), int'(idx8 == 3'(n - 1)));
        end
        cd = done8;
      end
      if (cd != 2'b00) begin
        dones++;
        seen = 1'b1;
        chk("bp_done_value", int'(cd), 1);
      end
    end
    chk("bp_beat_count", beats, n);
    chk("bp_done_count", dones, 1);
    @(posedge clk); #1;
    if (which == 5) begin
      chk("bp_done_single", int'(done5), 0);
      chk("bp_busy_after", int'(busy5), 0);
    end else begin
      chk("bp_done_single", int'(done8), 0);
      chk("bp_busy_after", int'(busy8), 0);
    end
    if (which == 5) rdy5 = 1'b0; else rdy8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req8 = 2'b00; req5 = 2'b00; abort8 = 1'b0; abort5 = 1'b0;
    rdy8 = 1'b0; rdy5 = 1'b0;

    // Reset held with both requesting
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1);
    add(0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1);

    // Single sweep for requester 0
    add(0, 2'b01, 0, 1, 2'b01, 0, 1, 2'b00, 1, 2);
    for (int i = 1; i < 8; i++) add(0, 2'b00, 0, 1, 2'b01, i, 1, 2'b00, 1, 2);
    add(0, 2'b00, 0, 1, 2'b00, 0, 0, 2'b01, 1, 2);
    add(0, 2'b00, 1, 1, 2'b00, 0, 0, 2'b00, 0, 2);   // abort in DONE ignored
    add(0, 2'b00, 1, 1, 2'b00, 0, 0, 2'b00, 0, 2);   // abort in IDLE ignored

    // Fairness with both requests held
    add(1, 2'b11, 0, 1, 2'b00, 0, 0, 2'b00, 0, 4);
    add_sweep(2'b11, 2'b01, 4);
    add_sweep(2'b11, 2'b10, 4);
    add_sweep(2'b11, 2'b01, 4);
    add_sweep(2'b11, 2'b10, 4);

    // Abort at idx=3 with a same-cycle accept, then the other requester wins
    add(1, 2'b00, 0, 1, 2'b00, 0, 0, 2'b00, 0, 5);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 0, 1, 2'b01, i, 1, 2'b00, 1, 5);
    add(0, 2'b11, 1, 1, 2'b00, 0, 0, 2'b00, 0, 5);
    add(0, 2'b11, 0, 1, 2'b10, 0, 1, 2'b00, 1, 5);

    // Reset in the middle of requester 1's sweep, then requester 0 wins the tie
    for (int i = 1; i < 6; i++) add(0, 2'b11, 0, 1, 2'b10, i, 1, 2'b00, 1, 6);
    add(1, 2'b11, 0, 1, 2'b00, 0, 0, 2'b00, 0, 6);
    add(0, 2'b11, 0, 1, 2'b01, 0, 1, 2'b00, 1, 6);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 6);

    #1;
    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; req8 = vecs[k].req; abort8 = vecs[k].abort; rdy8 = vecs[k].rdy;
      @(posedge clk); #1;
      n_cmp++;
      if ({gnt8, idx8, vld8, last8, done8, busy8} !=
          {vecs[k].gnt, vecs[k].idx, vecs[k].vld, vecs[k].last, vecs[k].done, vecs[k].busy}) begin
        n_fail++;
        $display("FAIL vec%0d(test%0d): got gnt=%b idx=%0d vld=%b last=%b done=%b busy=%b, expected gnt=%b idx=%0d vld=%b last=%b done=%b busy=%b",
                 k, vecs[k].tag, gnt8, idx8, vld8, last8, done8, busy8,
                 vecs[k].gnt, vecs[k].idx, vecs[k].vld, vecs[k].last, vecs[k].done, vecs[k].busy);
      end
    end
    rst = 1'b0; req8 = 2'b00; abort8 = 1'b0; rdy8 = 1'b0;

    // Random backpressure on the power-of-2 and non-power-of-2 instances
    run_bp(8, 8);
    run_bp(8, 8);
    run_bp(5, 5);
    run_bp(5, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
